// File: rtl/pipe_stall_ctrl_if.sv
// Pipeline control bundle: hazard/status inputs from the datapath and the
// per-stage enable/clear, redirect and stall-count outputs back to it.
interface pipe_stall_ctrl_if #(
  parameter int PC_W  = 32,
  parameter int CNT_W = 32
);
  logic             inst_busy;
  logic             data_busy;
  logic             load_use;
  logic             div_req;
  logic             div_done;
  logic             exc_req;
  logic [PC_W-1:0]  exc_target;
  logic             enF, enD, enE, enM, enW;
  logic             clrD, clrE, clrM, clrW;
  logic             redirect;
  logic [PC_W-1:0]  redirect_pc;
  logic [CNT_W-1:0] stall_cycles;

  modport master (
    input  inst_busy, data_busy, load_use, div_req, div_done, exc_req, exc_target,
    output enF, enD, enE, enM, enW, clrD, clrE, clrM, clrW,
    output redirect, redirect_pc, stall_cycles
  );

  modport slave (
    output inst_busy, data_busy, load_use, div_req, div_done, exc_req, exc_target,
    input  enF, enD, enE, enM, enW, clrD, clrE, clrM, clrW,
    input  redirect, redirect_pc, stall_cycles
  );
endinterface

// File: rtl/pipe_stall_ctrl.sv
// Pipeline stall/flush controller: sole source of F/D/E/M/W register
// enables and clears, with exception drain-then-redirect sequencing.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   S_RUN   | normal flow; hazards resolved combinationally each cycle
//   S_DIV   | waiting on divider; E held, bubbles into M
//   S_DRAIN | exception taken; pipeline frozen until bus goes idle
//   S_REDIR | single cycle: redirect PC and flush D..W
module pipe_stall_ctrl #(
  parameter int PC_W  = 32,
  parameter int CNT_W = 32
) (
  input logic             clk,
  input logic             rst,
  pipe_stall_ctrl_if.master bus
);

  typedef enum logic [1:0] {S_RUN, S_DIV, S_DRAIN, S_REDIR} state_t;

  state_t           state, next_state;
  logic [PC_W-1:0]  target;
  logic [CNT_W-1:0] stall_cnt;
  logic             latch_tgt;
  logic             en_f, en_d, en_e, en_m, en_w;
  logic             clr_d, clr_e, clr_m, clr_w;
  logic             redir;
  logic [PC_W-1:0]  redir_pc;

  // State and latched exception target
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_RUN;
      target <= '0;
    end else begin
      state <= next_state;
      if (latch_tgt) target <= bus.exc_target;
    end
  end

  // Stall cycle counter: counts fetch-stalled cycles, saturates at all-ones
  always_ff @(posedge clk) begin
    if (rst) stall_cnt <= '0;
    else if (!en_f && (stall_cnt != '1)) stall_cnt <= stall_cnt + CNT_W'(1);
  end

  // Next state and stage enables/clears
  always_comb begin
    next_state = state;
    latch_tgt  = 1'b0;
    en_f = 1'b1; en_d = 1'b1; en_e = 1'b1; en_m = 1'b1; en_w = 1'b1;
    clr_d = 1'b0; clr_e = 1'b0; clr_m = 1'b0; clr_w = 1'b0;
    redir    = 1'b0;
    redir_pc = '0;
    if (rst) begin
      en_f = 1'b0; en_d = 1'b0; en_e = 1'b0; en_m = 1'b0; en_w = 1'b0;
      clr_d = 1'b1; clr_e = 1'b1; clr_m = 1'b1; clr_w = 1'b1;
      next_state = S_RUN;
    end else if (((state == S_RUN) || (state == S_DIV)) && bus.exc_req) begin
      // Freeze everything; the faulting M instruction must not retire
      en_f = 1'b0; en_d = 1'b0; en_e = 1'b0; en_m = 1'b0; en_w = 1'b0;
      latch_tgt  = 1'b1;
      next_state = (bus.inst_busy || bus.data_busy) ? S_DRAIN : S_REDIR;
    end else begin
      case (state)
        S_RUN: begin
          if (bus.data_busy) begin
            en_f = 1'b0; en_d = 1'b0; en_e = 1'b0; en_m = 1'b0;
            clr_w = 1'b1;
          end else if (bus.div_req && !bus.div_done) begin
            en_f = 1'b0; en_d = 1'b0; en_e = 1'b0;
            clr_m = 1'b1;
            next_state = S_DIV;
          end else if (bus.load_use) begin
            en_f = 1'b0; en_d = 1'b0;
            clr_e = 1'b1;
          end else if (bus.inst_busy) begin
            en_f = 1'b0;
            clr_d = 1'b1;
          end
        end
        S_DIV: begin
          if (bus.data_busy) begin
            en_f = 1'b0; en_d = 1'b0; en_e = 1'b0; en_m = 1'b0;
            clr_w = 1'b1;
          end else if (bus.div_done) begin
            next_state = S_RUN;
          end else begin
            en_f = 1'b0; en_d = 1'b0; en_e = 1'b0;
            clr_m = 1'b1;
          end
        end
        S_DRAIN: begin
          en_f = 1'b0; en_d = 1'b0; en_e = 1'b0; en_m = 1'b0; en_w = 1'b0;
          if (!bus.inst_busy && !bus.data_busy) next_state = S_REDIR;
        end
        S_REDIR: begin
          redir    = 1'b1;
          redir_pc = target;
          clr_d = 1'b1; clr_e = 1'b1; clr_m = 1'b1; clr_w = 1'b1;
          next_state = S_RUN;
        end
        default: next_state = S_RUN;
      endcase
    end
  end

  assign bus.enF          = en_f;
  assign bus.enD          = en_d;
  assign bus.enE          = en_e;
  assign bus.enM          = en_m;
  assign bus.enW          = en_w;
  assign bus.clrD         = clr_d;
  assign bus.clrE         = clr_e;
  assign bus.clrM         = clr_m;
  assign bus.clrW         = clr_w;
  assign bus.redirect     = redir;
  assign bus.redirect_pc  = redir_pc;
  assign bus.stall_cycles = stall_cnt;

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Directed bench for pipe_stall_ctrl (counter width 4 to exercise saturation).
module tb_pipe_stall_ctrl;
  logic clk = 1'b0;
  logic rst;
  int   cmp = 0;
  int   mism = 0;

  pipe_stall_ctrl_if #(.PC_W(32), .CNT_W(4)) bus ();
  pipe_stall_ctrl #(.PC_W(32), .CNT_W(4)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  logic [4:0] en_v;
  logic [3:0] clr_v;
  assign en_v  = {bus.enF, bus.enD, bus.enE, bus.enM, bus.enW};
  assign clr_v = {bus.clrD, bus.clrE, bus.clrM, bus.clrW};

  task automatic next_cycle;
    @(posedge clk); #1;
  endtask

  task automatic idle_inputs;
    bus.inst_busy = 0; bus.data_busy = 0; bus.load_use = 0;
    bus.div_req = 0; bus.div_done = 0; bus.exc_req = 0; bus.exc_target = '0;
  endtask

  task automatic do_reset;
    rst = 1; idle_inputs();
    next_cycle(); next_cycle();
    rst = 0;
  endtask

  task automatic test_reset;
    rst = 1; idle_inputs();
    next_cycle(); next_cycle(); next_cycle();
    @(negedge clk);
    cmp++; if (en_v !== 5'b00000) begin mism++; $display("FAIL rst_en got %b want 00000", en_v); end
    cmp++; if (clr_v !== 4'b1111) begin mism++; $display("FAIL rst_clr got %b want 1111", clr_v); end
    cmp++; if (bus.stall_cycles !== 4'd0) begin mism++; $display("FAIL rst_stall got %0d want 0", bus.stall_cycles); end
    cmp++; if (bus.redirect !== 1'b0 || bus.redirect_pc !== 32'h0) begin mism++; $display("FAIL rst_redir got %b/%h want 0/0", bus.redirect, bus.redirect_pc); end
    next_cycle(); rst = 0;
    @(negedge clk);
    cmp++; if (en_v !== 5'b11111 || clr_v !== 4'b0000) begin mism++; $display("FAIL rst_release got %b/%b want 11111/0000", en_v, clr_v); end
    next_cycle();
  endtask

  task automatic test_load_use;
    do_reset();
    bus.load_use = 1;
    @(negedge clk);
    cmp++; if (en_v !== 5'b00111 || clr_v !== 4'b0100) begin mism++; $display("FAIL lu_stall got %b/%b want 00111/0100", en_v, clr_v); end
    next_cycle(); bus.load_use = 0;
    @(negedge clk);
    cmp++; if (en_v !== 5'b11111 || clr_v !== 4'b0000) begin mism++; $display("FAIL lu_after got %b/%b want 11111/0000", en_v, clr_v); end
    cmp++; if (bus.stall_cycles !== 4'd1) begin mism++; $display("FAIL lu_count got %0d want 1", bus.stall_cycles); end
    next_cycle();
  endtask

  task automatic test_priority;
    do_reset();
    bus.data_busy = 1; bus.load_use = 1; bus.inst_busy = 1; bus.div_req = 1;
    @(negedge clk);
    cmp++; if (en_v !== 5'b00001 || clr_v !== 4'b0001) begin mism++; $display("FAIL pri_data got %b/%b want 00001/0001", en_v, clr_v); end
    next_cycle(); bus.data_busy = 0; bus.div_req = 0;
    @(negedge clk);
    cmp++; if (en_v !== 5'b00111 || clr_v !== 4'b0100) begin mism++; $display("FAIL pri_lu got %b/%b want 00111/0100", en_v, clr_v); end
    next_cycle(); bus.load_use = 0;
    @(negedge clk);
    cmp++; if (en_v !== 5'b01111 || clr_v !== 4'b1000) begin mism++; $display("FAIL pri_inst got %b/%b want 01111/1000", en_v, clr_v); end
    next_cycle(); bus.inst_busy = 0;
    @(negedge clk);
    cmp++; if (en_v !== 5'b11111 || clr_v !== 4'b0000) begin mism++; $display("FAIL pri_idle got %b/%b want 11111/0000", en_v, clr_v); end
    next_cycle();
  endtask

  task automatic test_divide;
    do_reset();
    bus.div_req = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      cmp++; if (en_v !== 5'b00011 || clr_v !== 4'b0010) begin mism++; $display("FAIL div_wait%0d got %b/%b want 00011/0010", i, en_v, clr_v); end
      next_cycle();
    end
    bus.div_done = 1;
    @(negedge clk);
    cmp++; if (en_v !== 5'b11111 || clr_v !== 4'b0000) begin mism++; $display("FAIL div_done got %b/%b want 11111/0000", en_v, clr_v); end
    next_cycle(); bus.div_req = 0; bus.div_done = 0;
    @(negedge clk);
    cmp++; if (en_v !== 5'b11111) begin mism++; $display("FAIL div_exit got %b want 11111", en_v); end
    cmp++; if (bus.stall_cycles !== 4'd3) begin mism++; $display("FAIL div_count got %0d want 3", bus.stall_cycles); end
    // Request and completion together: no DIV entry
    next_cycle(); bus.div_req = 1; bus.div_done = 1;
    @(negedge clk);
    cmp++; if (en_v !== 5'b11111) begin mism++; $display("FAIL div_same got %b want 11111", en_v); end
    next_cycle(); bus.div_req = 0; bus.div_done = 0;
    @(negedge clk);
    cmp++; if (en_v !== 5'b11111 || clr_v !== 4'b0000) begin mism++; $display("FAIL div_same_next got %b/%b want 11111/0000", en_v, clr_v); end
    next_cycle();
  endtask

  task automatic test_exc_idle;
    do_reset();
    bus.exc_req = 1; bus.exc_target = 32'hBFC00380;
    @(negedge clk);
    cmp++; if (en_v !== 5'b00000 || clr_v !== 4'b0000 || bus.redirect !== 1'b0) begin mism++; $display("FAIL exc_n got %b/%b/%b want 00000/0000/0", en_v, clr_v, bus.redirect); end
    next_cycle(); bus.exc_req = 0; bus.exc_target = 32'h0;
    @(negedge clk);
    cmp++; if (bus.redirect !== 1'b1 || bus.redirect_pc !== 32'hBFC00380) begin mism++; $display("FAIL exc_redir got %b/%h want 1/bfc00380", bus.redirect, bus.redirect_pc); end
    cmp++; if (en_v !== 5'b11111 || clr_v !== 4'b1111) begin mism++; $display("FAIL exc_flush got %b/%b want 11111/1111", en_v, clr_v); end
    next_cycle();
    @(negedge clk);
    cmp++; if (bus.redirect !== 1'b0 || en_v !== 5'b11111 || clr_v !== 4'b0000) begin mism++; $display("FAIL exc_run got %b/%b/%b want 0/11111/0000", bus.redirect, en_v, clr_v); end
    cmp++; if (bus.stall_cycles !== 4'd1) begin mism++; $display("FAIL exc_count got %0d want 1", bus.stall_cycles); end
    next_cycle();
  endtask

  task automatic test_exc_drain;
    do_reset();
    bus.exc_req = 1; bus.data_busy = 1; bus.exc_target = 32'h80000180;
    next_cycle(); bus.exc_req = 0; bus.exc_target = 32'h0;
    for (int i = 0; i < 3; i++) begin
      if (i == 2) bus.data_busy = 0;
      @(negedge clk);
      cmp++; if (en_v !== 5'b00000 || bus.redirect !== 1'b0) begin mism++; $display("FAIL drain%0d got %b/%b want 00000/0", i, en_v, bus.redirect); end
      next_cycle();
    end
    @(negedge clk);
    cmp++; if (bus.redirect !== 1'b1 || bus.redirect_pc !== 32'h80000180) begin mism++; $display("FAIL drain_redir got %b/%h want 1/80000180", bus.redirect, bus.redirect_pc); end
    next_cycle();
    @(negedge clk);
    cmp++; if (bus.redirect !== 1'b0) begin mism++; $display("FAIL drain_single got %b want 0", bus.redirect); end
    cmp++; if (bus.stall_cycles !== 4'd4) begin mism++; $display("FAIL drain_count got %0d want 4", bus.stall_cycles); end
    // Reset during DRAIN drops the pending redirect
    next_cycle(); bus.exc_req = 1; bus.inst_busy = 1; bus.exc_target = 32'h12345678;
    next_cycle(); bus.exc_req = 0; rst = 1;
    @(negedge clk);
    cmp++; if (en_v !== 5'b00000 || clr_v !== 4'b1111 || bus.redirect !== 1'b0) begin mism++; $display("FAIL drain_rst got %b/%b/%b want 00000/1111/0", en_v, clr_v, bus.redirect); end
    next_cycle(); rst = 0; bus.inst_busy = 0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      cmp++; if (bus.redirect !== 1'b0 || en_v !== 5'b11111) begin mism++; $display("FAIL drain_rst_run%0d got %b/%b want 0/11111", i, bus.redirect, en_v); end
      next_cycle();
    end
  endtask

  task automatic test_back_to_back;
    do_reset();
    bus.exc_req = 1; bus.exc_target = 32'hAAAA0000;
    next_cycle(); bus.exc_target = 32'h5555FFFC;
    @(negedge clk);
    cmp++; if (bus.redirect !== 1'b1 || bus.redirect_pc !== 32'hAAAA0000) begin mism++; $display("FAIL b2b_first got %b/%h want 1/aaaa0000", bus.redirect, bus.redirect_pc); end
    next_cycle();
    @(negedge clk);
    cmp++; if (bus.redirect !== 1'b0 || en_v !== 5'b00000) begin mism++; $display("FAIL b2b_gap got %b/%b want 0/00000", bus.redirect, en_v); end
    next_cycle(); bus.exc_req = 0; bus.exc_target = 32'h0;
    @(negedge clk);
    cmp++; if (bus.redirect !== 1'b1 || bus.redirect_pc !== 32'h5555FFFC) begin mism++; $display("FAIL b2b_second got %b/%h want 1/5555fffc", bus.redirect, bus.redirect_pc); end
    next_cycle();
  endtask

  task automatic test_saturation;
    do_reset();
    bus.inst_busy = 1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (i == 15 || i == 19) begin
        cmp++; if (bus.stall_cycles !== 4'd15) begin mism++; $display("FAIL sat%0d got %0d want 15", i, bus.stall_cycles); end
      end
      if (i == 14) begin
        cmp++; if (bus.stall_cycles !== 4'd14) begin mism++; $display("FAIL sat14 got %0d want 14", bus.stall_cycles); end
      end
      next_cycle();
    end
    bus.inst_busy = 0;
    @(negedge clk);
    cmp++; if (bus.stall_cycles !== 4'd15) begin mism++; $display("FAIL sat_hold got %0d want 15", bus.stall_cycles); end
    next_cycle();
  endtask

  initial begin
    rst = 1;
    idle_inputs();
    test_reset();
    test_load_use();
    test_priority();
    test_divide();
    test_exc_idle();
    test_exc_drain();
    test_back_to_back();
    test_saturation();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, mism);
    $finish;
  end

endmodule

// File: doc/pipe_stall_ctrl.md
# pipe_stall_ctrl

Pipeline control unit that drives the per-stage enable and clear inputs of the F/D/E/M/W pipeline registers (`enX`/`clrX`). It arbitrates instruction-fetch stalls, data-memory stalls, load-use hazards, multi-cycle divide and exceptions. When an exception is raised, it drains outstanding bus transactions before issuing the redirect. It sits beside the datapath in the mycpu core and is the only source of pipeline register enables and clears.

## Interface
- PC_W, 32, width of the redirect target
- CNT_W, 32, width of the stall cycle counter
- clk  in  1  core clock
- rst  in  1  reset, synchronous, active-high
- inst_busy  in  1  instruction fetch outstanding; F cannot deliver
- data_busy  in  1  data access of the M-stage instruction outstanding
- load_use  in  1  D-stage instruction needs a load result currently in E
- div_req  in  1  E holds div/divu (level)
- div_done  in  1  divider result valid (1-cycle pulse)
- exc_req  in  1  M-stage instruction takes an exception or eret (level)
- exc_target  in  PC_W  handler/EPC address, valid with exc_req
- enF, enD, enE, enM, enW  out  1 each  stage register enable (0 = hold)
- clrD, clrE, clrM, clrW  out  1 each  stage register clear (insert bubble; wins over enable)
- redirect  out  1  one-cycle PC redirect strobe
- redirect_pc  out  PC_W  redirect target, valid with redirect
- stall_cycles  out  CNT_W  count of cycles with enF=0

## Operation
- FSM states: RUN, DIV, DRAIN, REDIR. Outputs are combinational from state, inputs and the latched target.
- RUN outputs, highest priority first:
  - exc_req: all en=0, all clr=0. Latch exc_target. Next state is DRAIN if inst_busy|data_busy, else REDIR.
  - data_busy: enF..enM=0; enW=1, clrW=1.
  - div_req & ~div_done: enF,enD,enE=0; enM=1, clrM=1; enW=1. Next state DIV.
  - load_use: enF,enD=0; enE=1, clrE=1; enM,enW=1.
  - inst_busy: enF=0; enD=1, clrD=1; enE,enM,enW=1.
  - Otherwise: all en=1, all clr=0.
  - div_req & div_done in the same RUN cycle advances normally with no DIV entry.
- DIV:
  - data_busy gives the RUN data_busy pattern.
  - Otherwise E is held, with a bubble into M and W advancing.
  - div_done: all en=1, clr=0, next RUN.
  - exc_req behaves as in RUN. Exception priority is not required in DIV because M carries only bubbles, but it is honoured if asserted.
- DRAIN:
  - All en=0, clr=0.
  - Leave to REDIR in the cycle after both inst_busy=0 and data_busy=0 are sampled.
  - Other inputs are ignored.
- REDIR (exactly one cycle):
  - redirect=1, redirect_pc=latched target.
  - enF..enW=1, clrD..clrW=1.
  - Next state RUN. All inputs are ignored, including a new exc_req.
- stall_cycles: +1 on each non-reset cycle with enF=0, saturating at all-ones with no wrap.

## Timing
- Reset values: state RUN, target 0, stall_cycles 0.
- Outputs while rst=1: en all 0, clrD..clrW=1, redirect=0, redirect_pc=0.
- rst has priority in any state, including mid-DRAIN or mid-DIV. State returns to RUN the next cycle and any pending redirect is dropped.
- Hazard response is same-cycle (combinational). There is no added latency in RUN.
- Exception with no bus activity: exc_req sampled in cycle n, redirect in cycle n+1.
- Exception with k busy cycles remaining: redirect in the cycle after busy deasserts.
- redirect is never high for two consecutive cycles.
- A clr asserted together with its en set to 1 loads zero. clr=1 with en=0 does not occur except during reset.

## Test plan
- Reset: hold rst 3 cycles -> en all 0, clrD..W=1, stall_cycles=0. After release with idle inputs -> all en=1.
- Load-use: load_use=1 for 1 cycle -> enF=enD=0, clrE=1 that cycle. Next cycle all en=1. stall_cycles=1.
- Divide: div_req held and div_done pulsed 3 cycles later -> 3 cycles of enE=0/clrM=1, then all en=1 in the div_done cycle.
- Exception idle: exc_req, exc_target=0xBFC00380 at cycle n -> all en=0 at n. At n+1: redirect=1, redirect_pc=0xBFC00380, clrD..W=1. RUN at n+2.
- Exception drain: exc_req with data_busy high 2 more cycles -> DRAIN holds all en=0. redirect fires the cycle after data_busy falls. Reset asserted mid-DRAIN -> no redirect.
- Saturation: CNT_W=4, inst_busy held 20 cycles -> stall_cycles reaches 15 and stays at 15.
